// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// Receive side of the UART peripheral. Recovers 8N1 frames from an
// asynchronous serial line at a programmable clocks-per-bit rate (same 16-bit
// divisor format as the transmitter) and holds the last good byte for the
// register block to read.
//
// Ports:
//   i_Clk        system clock, all logic on the rising edge
//   i_Rst_n      asynchronous active-low reset
//   i_UART_RX    asynchronous serial input, idle high
//   i_ClksPerBit bit period in i_Clk cycles, latched at start-bit detection
//   i_RdAck      one-cycle pulse: holding register consumed
//   o_Data       last successfully received byte
//   o_Valid      one-cycle pulse when a good byte is loaded into o_Data
//   o_Avail      level: an unread byte is present
//   o_Overrun    sticky: a byte arrived while o_Avail was already set
//   o_FrameErr   one-cycle pulse: stop bit sampled low
//   o_Idle       high while the receive FSM is in IDLE
//   o_State      current FSM state, for debug/observation only
//
// Handshake: o_Valid pulses for exactly one cycle together with the o_Data
// update; o_Avail rises on the same cycle and stays up until the consumer
// pulses i_RdAck, which clears o_Avail and o_Overrun on the next edge.
// There is no back-pressure: a byte arriving while o_Avail=1 still
// overwrites o_Data and sets o_Overrun, unless i_RdAck lands on that very
// load cycle, in which case the ack is taken to have consumed the previous
// byte (o_Avail=1, o_Overrun=0).
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_UART_RX,
  input  logic [15:0] i_ClksPerBit,
  input  logic        i_RdAck,
  output logic [7:0]  o_Data,
  output logic        o_Valid,
  output logic        o_Avail,
  output logic        o_Overrun,
  output logic        o_FrameErr,
  output logic        o_Idle,
  output logic [1:0]  o_State
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_s_d;

  // fill_q tracks how far real line data has propagated through sync_q
  // since reset; its top bit is set once rx_s reflects the line rather than
  // the reset value of the flops.
  logic [SYNC_STAGES-1:0] fill_q;

  // armed is set once the real line has been seen high after reset. Without
  // it, a line that is low at reset release would look like a falling edge
  // (sync flops reset to 1) and start a frame in the middle of someone
  // else's character.
  logic                   armed;
  logic                   start_det;

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign start_det = armed && rx_s_d && !rx_s;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync_q <= '1;
      fill_q <= '0;
      rx_s_d <= 1'b1;
      armed  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_UART_RX};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      rx_s_d <= rx_s;
      if (fill_q[SYNC_STAGES-1] && rx_s) begin
        armed <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bit timing
  // ---------------------------------------------------------------------------
  state_t      state;
  logic [15:0] cpb_q;     // divisor latched at start detect, never below 2
  logic [15:0] cnt;       // cycle counter within the current bit
  logic [2:0]  bit_idx;   // data bit being received, LSB first
  logic [7:0]  shift;     // data bits collected so far
  logic [15:0] cpb_m1;
  logic [15:0] half_m1;

  // cpb_q >= 2 always, so half is at least 1 and neither term underflows.
  assign cpb_m1  = cpb_q - 16'd1;
  assign half_m1 = (cpb_q >> 1) - 16'd1;

  // ---------------------------------------------------------------------------
  // Receive FSM and holding register
  //
  // Sample points, counted from the edge-detect cycle E:
  //   start bit at E+half, data bit i at E+half+(i+1)*cpb,
  //   stop bit at E+half+9*cpb. Results appear the cycle after the stop
  //   sample, by which time the FSM is already back in IDLE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state      <= S_IDLE;
      cpb_q      <= 16'd2;
      cnt        <= 16'd0;
      bit_idx    <= 3'd0;
      shift      <= 8'h00;
      o_Data     <= 8'h00;
      o_Valid    <= 1'b0;
      o_Avail    <= 1'b0;
      o_Overrun  <= 1'b0;
      o_FrameErr <= 1'b0;
    end else begin
      o_Valid    <= 1'b0;
      o_FrameErr <= 1'b0;

      // A good-frame load further down overrides this clear.
      if (i_RdAck) begin
        o_Avail   <= 1'b0;
        o_Overrun <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (start_det) begin
            cpb_q <= (i_ClksPerBit < 16'd2) ? 16'd2 : i_ClksPerBit;
            cnt   <= 16'd0;
            state <= S_START;
          end
        end

        S_START: begin
          if (cnt == half_m1) begin
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            // A high line at mid start bit is a glitch: drop it silently.
            state   <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_DATA: begin
          if (cnt == cpb_m1) begin
            cnt            <= 16'd0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_STOP: begin
          if (cnt == cpb_m1) begin
            cnt   <= 16'd0;
            state <= S_IDLE;
            if (rx_s) begin
              o_Data    <= shift;
              o_Valid   <= 1'b1;
              o_Avail   <= 1'b1;
              // Coincident ack consumed the previous byte, so no overrun.
              o_Overrun <= i_RdAck ? 1'b0 : (o_Overrun | o_Avail);
            end else begin
              o_FrameErr <= 1'b1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_Idle  = (state == S_IDLE);
  assign o_State = state;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//
// Directed bench for uart_rx. Frames are driven bit-by-bit on the serial
// line; each good byte is pushed on exp_q when it is sent and popped when
// the DUT pulses o_Valid. Inputs change on the falling clock edge, outputs
// are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int SYNC_STAGES = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        line   = 1'b1;
  logic [15:0] cpb    = 16'd16;
  logic        rd_ack = 1'b0;

  logic [7:0]  o_Data;
  logic        o_Valid;
  logic        o_Avail;
  logic        o_Overrun;
  logic        o_FrameErr;
  logic        o_Idle;
  logic [1:0]  o_State;

  always #5 clk = ~clk;

  uart_rx #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_UART_RX    (line),
    .i_ClksPerBit (cpb),
    .i_RdAck      (rd_ack),
    .o_Data       (o_Data),
    .o_Valid      (o_Valid),
    .o_Avail      (o_Avail),
    .o_Overrun    (o_Overrun),
    .o_FrameErr   (o_FrameErr),
    .o_Idle       (o_Idle),
    .o_State      (o_State)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int v_count  = 0;
  int fe_count = 0;
  int last_valid_cyc = 0;
  int start_cyc = 0;
  int ack_cyc   = 0;
  int v_base    = 0;
  int lat       = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: counts pulses and compares every received byte.
  always @(negedge clk) begin
    if (rst_n && o_FrameErr) fe_count++;
    if (rst_n && o_Valid) begin
      v_count++;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL unexpected_valid: observed data 0x%0h expected no byte", o_Data);
      end else begin
        check("rx_data", 32'(o_Data), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a falling edge, return at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b, input logic stop, input int bit_cyc);
    start_cyc = cyc;
    line = 1'b0;
    repeat (bit_cyc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      repeat (bit_cyc) @(negedge clk);
    end
    line = stop;
    repeat (bit_cyc) @(negedge clk);
  endtask

  task automatic idle(input int n);
    line = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_data",    32'(o_Data),     32'h00);
    check("rst_valid",   32'(o_Valid),    32'd0);
    check("rst_avail",   32'(o_Avail),    32'd0);
    check("rst_overrun", 32'(o_Overrun),  32'd0);
    check("rst_frameerr",32'(o_FrameErr), 32'd0);
    check("rst_idle",    32'(o_Idle),     32'd1);
    rst_n = 1'b1;
    idle(10);

    // Basic frame at cpb=16.
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, 16);
    idle(20);
    check("a5_count", 32'(v_count),  32'd1);
    check("a5_data",  32'(o_Data),   32'hA5);
    check("a5_avail", 32'(o_Avail),  32'd1);
    check("a5_fe",    32'(fe_count), 32'd0);
    // Valid should land half+9*cpb = 152 cycles after the synced edge, +-1.
    lat = last_valid_cyc - start_cyc - SYNC_STAGES;
    check("a5_latency", 32'((lat >= 151) && (lat <= 153)), 32'd1);

    // Short low glitch: false start, nothing reported.
    line = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    check("glitch_count", 32'(v_count), 32'd1);
    check("glitch_idle",  32'(o_Idle),  32'd1);
    check("glitch_data",  32'(o_Data),  32'hA5);
    check("glitch_fe",    32'(fe_count),32'd0);
    pulse_ack();
    check("ack_avail", 32'(o_Avail), 32'd0);

    // Framing error, then a good frame after the line recovers.
    send_byte(8'h3C, 1'b0, 16);
    idle(32);
    check("fe_count", 32'(fe_count), 32'd1);
    check("fe_avail", 32'(o_Avail),  32'd0);
    check("fe_data",  32'(o_Data),   32'hA5);
    check("fe_vcount",32'(v_count),  32'd1);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1, 16);
    idle(20);
    check("5a_count", 32'(v_count),   32'd2);
    check("5a_data",  32'(o_Data),    32'h5A);
    check("5a_avail", 32'(o_Avail),   32'd1);
    check("5a_ovr",   32'(o_Overrun), 32'd0);
    pulse_ack();

    // Overrun: two bytes without an ack.
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1, 16);
    idle(4);
    exp_q.push_back(8'h22);
    send_byte(8'h22, 1'b1, 16);
    idle(20);
    check("ovr_data",  32'(o_Data),    32'h22);
    check("ovr_flag",  32'(o_Overrun), 32'd1);
    check("ovr_avail", 32'(o_Avail),   32'd1);
    pulse_ack();
    check("ovr_ack_avail", 32'(o_Avail),   32'd0);
    check("ovr_ack_flag",  32'(o_Overrun), 32'd0);

    // Ack on the exact load cycle of the second byte.
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1, 16);
    idle(4);
    check("coin_pre_avail", 32'(o_Avail), 32'd1);
    exp_q.push_back(8'h22);
    fork
      send_byte(8'h22, 1'b1, 16);
      begin
        // Stop sample edge is SYNC_STAGES+1+half+9*cpb edges after the start
        // bit is driven; raise ack just before it.
        repeat (SYNC_STAGES + 8 + 9 * 16) @(negedge clk);
        ack_cyc = cyc;
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
      end
    join
    idle(20);
    check("coin_load_cycle", 32'(last_valid_cyc - ack_cyc), 32'd1);
    check("coin_avail",      32'(o_Avail),   32'd1);
    check("coin_ovr",        32'(o_Overrun), 32'd0);
    check("coin_data",       32'(o_Data),    32'h22);
    pulse_ack();

    // Odd divisor, back-to-back frames.
    cpb = 16'd5;
    v_base = v_count;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h81);
    send_byte(8'h00, 1'b1, 5);
    send_byte(8'hFF, 1'b1, 5);
    send_byte(8'h81, 1'b1, 5);
    idle(20);
    check("cpb5_count", 32'(v_count - v_base), 32'd3);
    check("cpb5_data",  32'(o_Data),    32'h81);
    check("cpb5_ovr",   32'(o_Overrun), 32'd1);
    check("cpb5_fe",    32'(fe_count),  32'd1);
    pulse_ack();

    // Divisor 0 behaves as 2.
    cpb = 16'd0;
    v_base = v_count;
    exp_q.push_back(8'h96);
    exp_q.push_back(8'h4B);
    send_byte(8'h96, 1'b1, 2);
    send_byte(8'h4B, 1'b1, 2);
    idle(20);
    check("cpb0_count", 32'(v_count - v_base), 32'd2);
    check("cpb0_data",  32'(o_Data),    32'h4B);
    check("cpb0_avail", 32'(o_Avail),   32'd1);
    check("cpb0_ovr",   32'(o_Overrun), 32'd1);

    // Reset during data bit 4 of 0xC3, released while the line is still low.
    cpb = 16'd16;
    v_base = v_count;
    fork
      send_byte(8'hC3, 1'b1, 16);
      begin
        repeat (85) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data",  32'(o_Data),    32'h00);
        check("mid_rst_avail", 32'(o_Avail),   32'd0);
        check("mid_rst_ovr",   32'(o_Overrun), 32'd0);
        check("mid_rst_idle",  32'(o_Idle),    32'd1);
        check("mid_rst_valid", 32'(o_Valid),   32'd0);
        repeat (9) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    idle(40);
    check("post_rst_count", 32'(v_count - v_base), 32'd0);
    check("post_rst_fe",    32'(fe_count), 32'd1);
    check("post_rst_idle",  32'(o_Idle),   32'd1);
    check("post_rst_avail", 32'(o_Avail),  32'd0);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1, 16);
    idle(20);
    check("post_rst_data",  32'(o_Data),  32'h7E);
    check("post_rst_avail2",32'(o_Avail), 32'd1);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
